md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that owns the HI/LO registers for the pipelined CPU.
- Executes MULT/MULTU/DIV/DIVU with independently configurable latencies, and MTHI/MTLO writes.
- Provides a busy flag so the decode/stall logic can hold MFHI/MFLO and further MD instructions.
- Supports cancellation of an in-flight operation on exception/flush; HI/LO are then left untouched.

---
 rtl/md_unit.sv | 156 +++++++++++++++
 tb/tb_md_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the CPU HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU with configurable latency plus MTHI/MTLO writes.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PROD_W  = 2 * WIDTH;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt;
    logic [WIDTH-1:0]   b_q, b_nxt;
    logic [1:0]         op_q, op_nxt;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic               busy_nxt, done_nxt;

    logic [WIDTH-1:0]   res_hi, res_lo;

    // Arithmetic on the latched operands; op_q[0]=1 selects unsigned, op_q[1]=1 selects divide.
    logic               is_signed;
    logic [PROD_W-1:0]  mul_a, mul_b, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, q_u, r_u, quo, rem;

    always_comb begin
        is_signed = ~op_q[0];
        mul_a     = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
        mul_b     = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
        prod      = mul_a * mul_b;

        // Magnitude divide then re-sign: the most-negative / -1 case falls out as lo=a, hi=0.
        a_neg = is_signed & a_q[WIDTH-1];
        b_neg = is_signed & b_q[WIDTH-1];
        abs_a = a_neg ? (~a_q + WIDTH'(1)) : a_q;
        abs_b = b_neg ? (~b_q + WIDTH'(1)) : b_q;
        if (b_q == '0) begin
            q_u = '0;
            r_u = '0;
        end else begin
            q_u = abs_a / abs_b;
            r_u = abs_a % abs_b;
        end
        quo = (a_neg ^ b_neg) ? (~q_u + WIDTH'(1)) : q_u;
        rem = a_neg ? (~r_u + WIDTH'(1)) : r_u;

        if (!op_q[1]) begin
            res_hi = prod[PROD_W-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Next-state, issue, completion and cancellation.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        hi_nxt    = hi;
        lo_nxt    = lo;
        done_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        a_nxt     = a;
                        b_nxt     = b;
                        op_nxt    = op[1:0];
                        cnt_nxt   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_nxt = RUN;
                    end else if (op == OP_MTHI) begin
                        hi_nxt = a;
                    end else if (op == OP_MTLO) begin
                        lo_nxt = a;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi_nxt    = res_hi;
                        lo_nxt    = res_lo;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            op_q  <= op_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic, latency, MTHI/MTLO,
// cancellation, ignored starts and asynchronous reset.
module tb_md_unit;

    localparam int unsigned W = 32;
    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    md_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Issues an op, checks N busy cycles, returns in the done cycle (caller may issue back-to-back).
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int n, input logic [W-1:0] ph,
                          input logic [W-1:0] pl, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int poke);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y;
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_busy"}, W'(busy), W'(1));
            chk({tag, "_nodone"}, W'(done), W'(0));
            chk({tag, "_hold_hi"}, hi, ph);
            chk({tag, "_hold_lo"}, lo, pl);
            if (i == poke) begin
                start = 1'b1; op = OP_MTHI; a = 32'hDEAD;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_idle"}, W'(busy), W'(0));
        chk({tag, "_done"}, W'(done), W'(1));
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    task automatic cancel_op(input string tag, input int k, input logic [W-1:0] ph,
                             input logic [W-1:0] pl);
        start = 1'b1; op = OP_MULT; a = 32'd4; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= k; i++) begin
            chk({tag, "_busy"}, W'(busy), W'(1));
            if (i == k) cancel = 1'b1;
            @(negedge clk);
        end
        cancel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk({tag, "_idle"}, W'(busy), W'(0));
            chk({tag, "_nodone"}, W'(done), W'(0));
            chk({tag, "_hi"}, hi, ph);
            chk({tag, "_lo"}, lo, pl);
            @(negedge clk);
        end
    endtask

    task automatic mt_pair;
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", W'(busy), W'(0));
        op = OP_MTLO; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_hi", hi, 32'h1234);
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_busy", W'(busy), W'(0));
        chk("mtlo_done", W'(done), W'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, NM, 32'h0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        @(negedge clk);
        chk("mult_neg_pulse", W'(done), W'(0));

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, NM, 32'hFFFFFFFF,
               32'hFFFFFFFA, 32'hFFFFFFFE, 32'h00000001, 0);
        @(negedge clk);

        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, ND, 32'hFFFFFFFE, 32'h1,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, ND, 32'hFFFFFFFF, 32'hFFFFFFFD,
               32'd7, 32'hFFFFFFFF, 0);
        run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFFFFFE, ND, 32'd7, 32'hFFFFFFFF,
               32'd1, 32'hFFFFFFFD, 0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, ND, 32'd1, 32'hFFFFFFFD,
               32'h0, 32'h80000000, 0);
        @(negedge clk);
        chk("div_ovf_pulse", W'(done), W'(0));

        mt_pair();

        run_op("mult_poke", OP_MULT, 32'd2, 32'd3, NM, 32'h1234, 32'h5678,
               32'h0, 32'd6, 2);
        @(negedge clk);
        chk("poke_hi", hi, 32'h0);
        chk("poke_busy", W'(busy), W'(0));

        start = 1'b1; op = 3'd6; a = 32'hAAAA; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("rsvd_busy", W'(busy), W'(0));
        chk("rsvd_hi", hi, 32'h0);
        chk("rsvd_lo", lo, 32'd6);

        mt_pair();
        cancel_op("cancel3", 3, 32'h1234, 32'h5678);
        cancel_op("cancel5", 5, 32'h1234, 32'h5678);

        start = 1'b1; cancel = 1'b1; op = OP_MTHI; a = 32'hBEEF;
        @(negedge clk);
        op = OP_MULT; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idlecan_hi", hi, 32'h1234);
        chk("idlecan_busy", W'(busy), W'(0));
        @(negedge clk);
        chk("idlecan_busy2", W'(busy), W'(0));
        chk("idlecan_lo", lo, 32'h5678);

        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_prebusy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_busy", W'(busy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", OP_MULT, 32'd3, 32'd5, NM, 32'h0, 32'h0, 32'h0, 32'hF, 0);
        @(negedge clk);
        chk("post_rst_pulse", W'(done), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
